xif_copro_issue_buffer: RTL

In-order buffer between the XIF issue interface (after the coprocessor predecoder) and the coprocessor execution unit. Holds accepted offloaded instructions with their source operands until the core commits or kills them. Forwards committed instructions to the execution unit in issue order and silently drops killed ones.

---
 rtl/xif_copro_pkg.sv | 22 ++
 rtl/xif_copro_issue_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/xif_copro_pkg.sv
// Shared types for the XIF coprocessor issue buffer.
// Entry state encoding and the stored entry bundle.
package xif_copro_pkg;

   localparam int unsigned XIF_ID_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_PENDING   = 2'd1,
      ST_COMMITTED = 2'd2,
      ST_KILLED    = 2'd3
   } entry_state_e;

   typedef struct packed {
      logic [31:0]             instr;
      logic [XIF_ID_WIDTH-1:0] id;
      logic [31:0]             rs1;
      logic [31:0]             rs2;
      entry_state_e            state;
   } issue_entry_t;

endpackage

// File: rtl/xif_copro_issue_buffer.sv
// In-order buffer holding offloaded instructions until commit/kill,
// then dispatching committed ones to the coprocessor execution unit.
module xif_copro_issue_buffer
   import xif_copro_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        issue_valid_i,
   output logic                        issue_ready_o,
   input  logic [31:0]                 issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]       issue_id_i,
   input  logic [31:0]                 issue_rs1_i,
   input  logic [31:0]                 issue_rs2_i,
   input  logic [1:0]                  issue_rs_valid_i,
   input  logic                        prd_accept_i,
   input  logic [1:0]                  prd_use_gprs_i,
   input  logic                        commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]       commit_id_i,
   input  logic                        commit_kill_i,
   output logic                        ex_valid_o,
   input  logic                        ex_ready_i,
   output logic [31:0]                 ex_instr_o,
   output logic [X_ID_WIDTH-1:0]       ex_id_o,
   output logic [31:0]                 ex_rs1_o,
   output logic [31:0]                 ex_rs2_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        empty_o,
   output logic                        full_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   issue_entry_t  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic         ops_ok;
   logic         push;
   logic         pop;
   logic         head_kill;
   issue_entry_t head_entry;
   issue_entry_t new_entry;

   assign count_o = count;
   assign full_o  = (count == CW'(DEPTH));
   assign empty_o = (count == '0);

   assign ops_ok = ((issue_rs_valid_i & prd_use_gprs_i) == prd_use_gprs_i);
   assign issue_ready_o = prd_accept_i ? (!full_o && ops_ok) : 1'b1;
   assign push = issue_valid_i && issue_ready_o && prd_accept_i;

   assign head_entry = mem[head];
   assign ex_valid_o = (head_entry.state == ST_COMMITTED);
   assign head_kill  = (head_entry.state == ST_KILLED);
   assign pop        = (ex_valid_o && ex_ready_i) || head_kill;

   assign ex_instr_o = ex_valid_o ? head_entry.instr : '0;
   assign ex_id_o    = ex_valid_o ? head_entry.id    : '0;
   assign ex_rs1_o   = ex_valid_o ? head_entry.rs1   : '0;
   assign ex_rs2_o   = ex_valid_o ? head_entry.rs2   : '0;

   // A commit naming the instruction being pushed resolves it on entry
   always_comb begin
      new_entry       = '0;
      new_entry.instr = issue_instr_i;
      new_entry.id    = issue_id_i;
      new_entry.rs1   = prd_use_gprs_i[0] ? issue_rs1_i : '0;
      new_entry.rs2   = prd_use_gprs_i[1] ? issue_rs2_i : '0;
      new_entry.state = ST_PENDING;
      if (commit_valid_i && (commit_id_i == issue_id_i)) begin
         new_entry.state = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && (mem[i].state == ST_PENDING) &&
                (mem[i].id == commit_id_i)) begin
               mem[i].state <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
            end
         end
         if (pop) begin
            mem[head].state <= ST_FREE;
            head            <= head + 1'b1;
         end
         if (push) begin
            mem[tail] <= new_entry;
            tail      <= tail + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule
